// File: rtl/minmax_tracker.sv
// Running max/min tracker over a fixed-length stream of unsigned 8-bit samples.
// Two magnitude comparators check each sample against the current max and min.

module mag_cmp8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       lt,
    output logic       gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

module minmax_tracker #(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       max_out,
    output logic [7:0]       min_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    state_t           state, state_nxt;
    logic             xfer;
    logic [CNT_W-1:0] count_inc;
    logic             above_max, below_min;
    logic             unused_max_lt, unused_min_gt;

    mag_cmp8 u_cmp_max (
        .a  (in_data),
        .b  (max_out),
        .lt (unused_max_lt),
        .gt (above_max)
    );

    mag_cmp8 u_cmp_min (
        .a  (in_data),
        .b  (min_out),
        .lt (below_min),
        .gt (unused_min_gt)
    );

    // Handshake decodes come from registered state only, so nothing in in_data reaches an output.
    assign in_ready  = (state == FIRST) || (state == RUN);
    assign busy      = in_ready;
    assign done      = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign count_inc = count + CNT_W'(1);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FIRST;
            FIRST:      if (xfer)  state_nxt = (N_SAMPLES == 1) ? DONE : RUN;
            RUN:        if (xfer && (count_inc == N_LAST)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            max_out <= 8'h00;
            min_out <= 8'hFF;
            count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) count <= '0;
                end
                FIRST: begin
                    if (xfer) begin
                        max_out <= in_data;
                        min_out <= in_data;
                        count   <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (above_max) max_out <= in_data;
                        if (below_min) min_out <= in_data;
                        count <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: one N=4 instance and one N=1 instance share stimulus.

module tb_minmax_tracker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy4, busy4, done4;
    logic [7:0] max4, min4;
    logic [4:0] cnt4;
    logic       rdy1, busy1, done1;
    logic [7:0] max1, min1;
    logic [4:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    minmax_tracker #(.N_SAMPLES(4), .CNT_W(5)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy4), .in_data(in_data), .max_out(max4), .min_out(min4),
        .count(cnt4), .busy(busy4), .done(done4)
    );

    minmax_tracker #(.N_SAMPLES(1), .CNT_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(rdy1), .in_data(in_data), .max_out(max1), .min_out(min1),
        .count(cnt1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full observable state of the N=4 instance.
    task automatic check4(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                          input logic [4:0] c, input logic bz, input logic dn);
        check({tag, ".max"},   32'(max4),  32'(mx));
        check({tag, ".min"},   32'(min4),  32'(mn));
        check({tag, ".count"}, 32'(cnt4),  32'(c));
        check({tag, ".busy"},  32'(busy4), 32'(bz));
        check({tag, ".ready"}, 32'(rdy4),  32'(bz));
        check({tag, ".done"},  32'(done4), 32'(dn));
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic stall(input logic [7:0] junk);
        in_valid = 1'b0;
        in_data  = junk;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        check4("reset", 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0);
        check("reset.n1.done", 32'(done1), 32'd0);
        check("reset.n1.min",  32'(min1),  32'hFF);
        rst_n = 1'b1;
        tick();
        check4("idle", 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0);

        // Reset mid-run after three samples.
        start = 1'b1; tick(); start = 1'b0;
        check4("first", 8'h00, 8'hFF, 5'd0, 1'b1, 1'b0);
        send(8'h11); send(8'h22); send(8'h33);
        check4("midrun", 8'h33, 8'h11, 5'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check4("async_rst", 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check4("post_rst", 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0);

        // Basic run, back-to-back samples.
        start = 1'b1; tick(); start = 1'b0;
        send(8'h05);
        check4("basic1", 8'h05, 8'h05, 5'd1, 1'b1, 1'b0);
        send(8'hC8);
        check4("basic2", 8'hC8, 8'h05, 5'd2, 1'b1, 1'b0);
        send(8'h03);
        check4("basic3", 8'hC8, 8'h03, 5'd3, 1'b1, 1'b0);
        send(8'h40);
        check4("basic4", 8'hC8, 8'h03, 5'd4, 1'b0, 1'b1);
        send(8'hFF);
        check4("frozen", 8'hC8, 8'h03, 5'd4, 1'b0, 1'b1);
        in_valid = 1'b0;

        // Duplicate values.
        start = 1'b1; tick(); start = 1'b0;
        check4("restart_keep", 8'hC8, 8'h03, 5'd0, 1'b1, 1'b0);
        send(8'h7F); send(8'h7F); send(8'h7F); send(8'h7F);
        check4("equal", 8'h7F, 8'h7F, 5'd4, 1'b0, 1'b1);
        in_valid = 1'b0;

        // Extremes.
        start = 1'b1; tick(); start = 1'b0;
        send(8'h00); send(8'hFF);
        check4("extreme2", 8'hFF, 8'h00, 5'd2, 1'b1, 1'b0);
        send(8'h80); send(8'h80);
        check4("extreme4", 8'hFF, 8'h00, 5'd4, 1'b0, 1'b1);
        in_valid = 1'b0;

        // Stalls: in_valid pattern 1,0,0,1,0,0,... with junk data on idle cycles.
        start = 1'b1; tick(); start = 1'b0;
        send(8'h10); stall(8'hFF); stall(8'h00);
        check4("stall1", 8'h10, 8'h10, 5'd1, 1'b1, 1'b0);
        send(8'h20); stall(8'hFF); stall(8'h00);
        send(8'h08); stall(8'hFF); stall(8'h00);
        check4("stall3", 8'h20, 8'h08, 5'd3, 1'b1, 1'b0);
        send(8'h30);
        check4("stall4", 8'h30, 8'h08, 5'd4, 1'b0, 1'b1);
        in_valid = 1'b0;

        // Start pulsed during RUN is ignored.
        start = 1'b1; tick(); start = 1'b0;
        send(8'h01);
        start = 1'b1; send(8'h02); start = 1'b0;
        check4("ign_start", 8'h02, 8'h01, 5'd2, 1'b1, 1'b0);
        send(8'h03); send(8'h04);
        check4("ign_done", 8'h04, 8'h01, 5'd4, 1'b0, 1'b1);

        // Restart from DONE with in_valid high: no transfer on the start cycle.
        start = 1'b1; in_valid = 1'b1; in_data = 8'h99; tick(); start = 1'b0;
        check4("restart", 8'h04, 8'h01, 5'd0, 1'b1, 1'b0);
        send(8'h55);
        check4("restart55", 8'h55, 8'h55, 5'd1, 1'b1, 1'b0);
        in_valid = 1'b0;

        // N_SAMPLES = 1 instance (sitting in DONE from earlier traffic).
        start = 1'b1; tick(); start = 1'b0;
        check("n1.busy",  32'(busy1), 32'd1);
        check("n1.done0", 32'(done1), 32'd0);
        check("n1.cnt0",  32'(cnt1),  32'd0);
        send(8'h9A);
        check("n1.done",  32'(done1), 32'd1);
        check("n1.max",   32'(max1),  32'h9A);
        check("n1.min",   32'(min1),  32'h9A);
        check("n1.cnt",   32'(cnt1),  32'd1);
        check("n1.idle",  32'(busy1), 32'd0);
        send(8'h01);
        check("n1.frz_max", 32'(max1), 32'h9A);
        check("n1.frz_min", 32'(min1), 32'h9A);
        check("n1.frz_cnt", 32'(cnt1), 32'd1);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
